// File: rtl/tx_conv_ctrl.sv
// Transmit sequencer feeding the rate-1/2 convolutional encoder: SIGNAL field,
// encoder flush gap, then scrambled SERVICE/PSDU/TAIL/PAD as one unbroken DATA field.
module tx_conv_ctrl #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk_Modulation,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  rate,
    input  logic [11:0] length,
    input  logic [6:0]  scr_seed,
    input  logic [7:0]  psdu_byte,
    input  logic        psdu_valid,
    output logic        psdu_ready,
    output logic        enc_valid,
    output logic        enc_bit,
    output logic        enc_signal,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = 12;
    localparam int unsigned SYM_W = 8;
    localparam int unsigned SIG_W = 24;

    typedef enum logic [2:0] {
        S_IDLE, S_SIGNAL, S_GAP, S_SERVICE, S_PSDU, S_TAIL, S_PAD, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [6:0]         seed_q, seed_d;
    logic [6:0]         scr_q, scr_d;
    logic [SYM_W-1:0]   ndbps_q, ndbps_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [7:0]         shift_q, shift_d;
    logic               enc_valid_q, enc_valid_d;
    logic               enc_bit_q, enc_bit_d;
    logic               enc_signal_q, enc_signal_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               psdu_ready_q, psdu_ready_d;

    logic [SYM_W-1:0]   ndbps_in;
    logic [SYM_W-1:0]   sym_nx;
    logic               scr_s;
    logic               sig_par;

    // Data bits per OFDM symbol for each legal RATE code; 0 marks an illegal code.
    function automatic logic [SYM_W-1:0] ndbps_of(input logic [3:0] r);
        logic [SYM_W-1:0] n;
        case (r)
            4'b1101: n = SYM_W'(24);
            4'b1111: n = SYM_W'(36);
            4'b0101: n = SYM_W'(48);
            4'b0111: n = SYM_W'(72);
            4'b1001: n = SYM_W'(96);
            4'b1011: n = SYM_W'(144);
            4'b0001: n = SYM_W'(192);
            4'b0011: n = SYM_W'(216);
            default: n = SYM_W'(0);
        endcase
        return n;
    endfunction

    assign ndbps_in = ndbps_of(rate);
    assign sig_par  = ^{rate, length};
    assign scr_s    = scr_q[6] ^ scr_q[3];
    assign sym_nx   = (sym_q == ndbps_q - SYM_W'(1)) ? SYM_W'(0) : sym_q + SYM_W'(1);

    assign psdu_ready = psdu_ready_q;
    assign enc_valid  = enc_valid_q;
    assign enc_bit    = enc_bit_q;
    assign enc_signal = enc_signal_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

    // State register and all datapath registers.
    always_ff @(posedge clk_Modulation or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sig_q        <= '0;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            acc_cnt_q    <= '0;
            seed_q       <= '0;
            scr_q        <= '0;
            ndbps_q      <= '0;
            sym_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            enc_valid_q  <= 1'b0;
            enc_bit_q    <= 1'b0;
            enc_signal_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 2'b00;
            psdu_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sig_q        <= sig_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            seed_q       <= seed_d;
            scr_q        <= scr_d;
            ndbps_q      <= ndbps_d;
            sym_q        <= sym_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            enc_valid_q  <= enc_valid_d;
            enc_bit_q    <= enc_bit_d;
            enc_signal_q <= enc_signal_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            psdu_ready_q <= psdu_ready_d;
        end
    end

    // Next state; state/counter name the bit that the coming edge registers onto enc_*.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sig_d        = sig_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        seed_d       = seed_q;
        scr_d        = scr_q;
        ndbps_d      = ndbps_q;
        sym_d        = sym_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        enc_valid_d  = 1'b0;
        enc_bit_d    = 1'b0;
        enc_signal_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 2'b00;

        if (psdu_valid && psdu_ready_q) begin
            hold_d      = psdu_byte;
            hold_full_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ndbps_in == SYM_W'(0) || length == LEN_W'(0) || scr_seed == 7'd0) begin
                        err_d = 2'b01;
                    end else begin
                        state_d     = S_SIGNAL;
                        busy_d      = 1'b1;
                        cnt_d       = '0;
                        len_d       = length;
                        seed_d      = scr_seed;
                        ndbps_d     = ndbps_in;
                        sig_d       = {6'b0, sig_par, length, 1'b0,
                                       rate[0], rate[1], rate[2], rate[3]};
                        acc_cnt_d   = '0;
                        byte_cnt_d  = '0;
                        hold_full_d = 1'b0;
                    end
                end
            end
            S_SIGNAL: begin
                enc_valid_d  = 1'b1;
                enc_signal_d = 1'b1;
                enc_bit_d    = sig_q[cnt_q[4:0]];
                if (cnt_q == CNT_W'(SIG_W - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_SERVICE;
                    cnt_d   = '0;
                    scr_d   = seed_q;
                    sym_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SERVICE: begin
                enc_valid_d = 1'b1;
                enc_bit_d   = scr_s;
                scr_d       = {scr_q[5:0], scr_s};
                sym_d       = sym_nx;
                if (cnt_q == CNT_W'(15)) begin
                    state_d    = S_PSDU;
                    cnt_d      = '0;
                    byte_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PSDU: begin
                if (cnt_q == CNT_W'(0) && !hold_full_q) begin
                    // Nothing to load at a byte boundary: abort the frame.
                    err_d   = 2'b10;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    enc_valid_d = 1'b1;
                    scr_d       = {scr_q[5:0], scr_s};
                    sym_d       = sym_nx;
                    if (cnt_q == CNT_W'(0)) begin
                        enc_bit_d   = hold_q[0] ^ scr_s;
                        shift_d     = {1'b0, hold_q[7:1]};
                        hold_full_d = 1'b0;
                    end else begin
                        enc_bit_d = shift_q[0] ^ scr_s;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (byte_cnt_q == len_q - LEN_W'(1)) begin
                            state_d = S_TAIL;
                        end else begin
                            byte_cnt_d = byte_cnt_q + LEN_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_TAIL: begin
                enc_valid_d = 1'b1;
                scr_d       = {scr_q[5:0], scr_s};
                sym_d       = sym_nx;
                if (cnt_q == CNT_W'(5)) begin
                    cnt_d   = '0;
                    state_d = (sym_nx == SYM_W'(0)) ? S_DONE : S_PAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PAD: begin
                enc_valid_d = 1'b1;
                enc_bit_d   = scr_s;
                scr_d       = {scr_q[5:0], scr_s};
                sym_d       = sym_nx;
                if (sym_nx == SYM_W'(0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        psdu_ready_d = (state_d == S_SIGNAL || state_d == S_GAP ||
                        state_d == S_SERVICE || state_d == S_PSDU) &&
                       !hold_full_d && (acc_cnt_d < len_d);
    end

endmodule

// File: tb/tb_tx_conv_ctrl.sv
// Randomised scoreboard bench for tx_conv_ctrl: a bit-level frame model fills an
// expectation queue, a monitor pops it whenever the encoder interface shows activity.
module tb_tx_conv_ctrl;

    localparam int GAP = 4;

    logic        clk_Modulation = 1'b0;
    logic        reset_n        = 1'b0;
    logic        start          = 1'b0;
    logic [3:0]  rate           = '0;
    logic [11:0] length         = '0;
    logic [6:0]  scr_seed       = '0;
    logic [7:0]  psdu_byte      = '0;
    logic        psdu_valid     = 1'b0;
    logic        psdu_ready;
    logic        enc_valid;
    logic        enc_bit;
    logic        enc_signal;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    tx_conv_ctrl #(.GAP_CYCLES(GAP)) dut (
        .clk_Modulation(clk_Modulation),
        .reset_n       (reset_n),
        .start         (start),
        .rate          (rate),
        .length        (length),
        .scr_seed      (scr_seed),
        .psdu_byte     (psdu_byte),
        .psdu_valid    (psdu_valid),
        .psdu_ready    (psdu_ready),
        .enc_valid     (enc_valid),
        .enc_bit       (enc_bit),
        .enc_signal    (enc_signal),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk_Modulation = ~clk_Modulation;

    typedef struct {
        int         idle;   // quiet cycles expected before this event, -1 = any
        logic       valid;
        logic       bval;
        logic       sig;
        logic       dn;
        logic [1:0] er;
    } exp_t;

    exp_t       exp_q[$];
    logic       cap_bits[$];
    logic [7:0] src_q[$];
    int         src_limit    = 1 << 30;
    int         src_sent     = 0;
    bit         src_rand     = 1'b0;
    int         ready_cycles = 0;
    int         n_cmp        = 0;
    int         n_err        = 0;
    int         ev_idx       = 0;
    logic [3:0] codes [8]    = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                                 4'b1001, 4'b1011, 4'b0001, 4'b0011};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic int ndbps(input logic [3:0] r);
        case (r)
            4'b1101: return 24;
            4'b1111: return 36;
            4'b0101: return 48;
            4'b0111: return 72;
            4'b1001: return 96;
            4'b1011: return 144;
            4'b0001: return 192;
            4'b0011: return 216;
            default: return 0;
        endcase
    endfunction

    task automatic push_exp(input int idle, input logic v, input logic b, input logic s,
                            input logic d, input logic [1:0] e);
        exp_t x;
        x.idle = idle; x.valid = v; x.bval = b; x.sig = s; x.dn = d; x.er = e;
        exp_q.push_back(x);
    endtask

    // Reference frame: field list, 802.11a scrambler, padding to whole symbols.
    task automatic model_frame(input logic [3:0] r, input int len, input logic [6:0] seed,
                               input logic [7:0] bytes[$], input int underrun_at);
        int   n, total, stop, tail0;
        logic sb[$];
        logic par, b, s;
        int   st;
        n = ndbps(r);
        if (n == 0 || len == 0 || seed == 7'd0) begin
            push_exp(-1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
            return;
        end
        for (int i = 3; i >= 0; i--) sb.push_back(r[i]);
        sb.push_back(1'b0);
        for (int i = 0; i < 12; i++) sb.push_back(len[i]);
        par = 1'b0;
        for (int i = 0; i < 17; i++) par = par ^ sb[i];
        sb.push_back(par);
        for (int i = 0; i < 6; i++) sb.push_back(1'b0);
        for (int i = 0; i < 24; i++) push_exp((i == 0) ? -1 : 0, 1'b1, sb[i], 1'b1, 1'b0, 2'b00);
        tail0 = 16 + 8 * len;
        total = ((tail0 + 6 + n - 1) / n) * n;
        stop  = (underrun_at >= 0) ? 16 + 8 * underrun_at : total;
        st    = int'(seed);
        for (int i = 0; i < stop; i++) begin
            b = 1'b0;
            if (i >= 16 && i < tail0) b = bytes[(i - 16) / 8][(i - 16) % 8];
            s  = 1'((st >> 6) ^ (st >> 3));
            st = ((st << 1) | int'(s)) & 'h7f;
            push_exp((i == 0) ? GAP : 0, 1'b1,
                     (i >= tail0 && i < tail0 + 6) ? 1'b0 : (b ^ s), 1'b0, 1'b0, 2'b00);
        end
        if (underrun_at >= 0) push_exp(0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        else                  push_exp(0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    endtask

    // Start cycle sits between two rising edges; returns just after the edge that samples it.
    task automatic pulse_start(input logic [3:0] r, input int len, input logic [6:0] seed);
        @(posedge clk_Modulation); #1;
        start = 1'b1; rate = r; length = 12'(len); scr_seed = seed;
        @(posedge clk_Modulation); #1;
        start = 1'b0;
    endtask

    task automatic issue_frame(input logic [3:0] r, input int len, input logic [6:0] seed,
                               input int underrun_at);
        logic [7:0] bytes[$];
        src_sent = 0;
        ready_cycles = 0;
        cap_bits.delete();
        for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
        if (ndbps(r) != 0 && len != 0 && seed != 7'd0)
            foreach (bytes[i]) src_q.push_back(bytes[i]);
        model_frame(r, len, seed, bytes, underrun_at);
        pulse_start(r, len, seed);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk_Modulation);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d expected events still pending", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk_Modulation);
        #1;
    endtask

    // Monitor: every active cycle must match the head of the expectation queue.
    initial begin
        exp_t x;
        int   idle = 0;
        forever begin
            @(negedge clk_Modulation);
            if (!reset_n) begin
                idle = 0;
            end else begin
                if (psdu_ready) ready_cycles++;
                if (enc_valid || done || err != 2'b00) begin
                    if (enc_valid) cap_bits.push_back(enc_bit);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL stream#%0d: unexpected v=%0b b=%0b s=%0b done=%0b err=%0b",
                                 ev_idx, enc_valid, enc_bit, enc_signal, done, err);
                    end else begin
                        x = exp_q.pop_front();
                        if ({enc_valid, enc_bit, enc_signal, done, err} !==
                                {x.valid, x.bval, x.sig, x.dn, x.er} ||
                            (x.idle >= 0 && idle != x.idle)) begin
                            n_err++;
                            $display("FAIL stream#%0d: got v=%0b b=%0b s=%0b done=%0b err=%0b gap=%0d, expected v=%0b b=%0b s=%0b done=%0b err=%0b gap=%0d",
                                     ev_idx, enc_valid, enc_bit, enc_signal, done, err, idle,
                                     x.valid, x.bval, x.sig, x.dn, x.er, x.idle);
                        end
                    end
                    ev_idx++;
                    idle = 0;
                end else begin
                    idle++;
                end
            end
        end
    end

    // PSDU source: presents queued bytes, optionally with random inter-byte stalls.
    initial begin
        bit fire;
        int stall = 0;
        forever begin
            @(negedge clk_Modulation);
            fire = psdu_valid && psdu_ready && reset_n;
            @(posedge clk_Modulation); #1;
            if (fire && src_q.size() > 0) begin
                void'(src_q.pop_front());
                src_sent++;
                stall = src_rand ? int'($urandom_range(0, 3)) : 0;
            end else if (stall > 0) begin
                stall--;
            end
            if (src_q.size() > 0 && src_sent < src_limit && stall == 0) begin
                psdu_valid = 1'b1;
                psdu_byte  = src_q[0];
            end else begin
                psdu_valid = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] sigv;
        logic [15:0] svc;
        logic [5:0]  tl;
        int          bseen;

        // Reset state
        repeat (3) @(posedge clk_Modulation);
        #1;
        chk("reset_outputs", 32'({psdu_ready, enc_valid, enc_bit, enc_signal, busy, done, err}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_Modulation);

        // 6 Mbps, one byte, all-ones seed; also first-bit latency
        issue_frame(4'b1101, 1, 7'h7F, -1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_low_first_cycle", 32'(enc_valid), 32'd0);
        @(posedge clk_Modulation); #1;
        chk("valid_second_clock", 32'({enc_valid, enc_signal}), 32'b11);
        wait_drain(3000);
        chk("f6_bit_count", 32'(cap_bits.size()), 32'(24 + 48));
        if (cap_bits.size() >= 40) begin
            for (int i = 0; i < 24; i++) sigv[23 - i] = cap_bits[i];
            for (int i = 0; i < 16; i++) svc[15 - i] = cap_bits[24 + i];
            chk("f6_signal_field", 32'(sigv), 32'(24'b110101_00000000000_0_000000));
            chk("f6_service_bits", 32'(svc), 32'(16'b0000111011110010));
        end
        chk("f6_ready_cycles", 32'(ready_cycles), 32'd1);
        chk("f6_bytes_taken", 32'(src_sent), 32'd1);

        // 54 Mbps, 100 bytes
        issue_frame(4'b0011, 100, 7'h7F, -1);
        wait_drain(3000);
        chk("f54_bit_count", 32'(cap_bits.size()), 32'(24 + 864));
        if (cap_bits.size() >= 24 + 822) begin
            for (int i = 0; i < 6; i++) tl[i] = cap_bits[24 + 816 + i];
            chk("f54_tail_zero", 32'(tl), 32'd0);
        end
        chk("f54_bytes_taken", 32'(src_sent), 32'd100);

        // Rejected requests: bad rate, zero length, zero seed
        for (int k = 0; k < 3; k++) begin
            issue_frame((k == 0) ? 4'b0000 : 4'b1101, (k == 1) ? 0 : 10,
                        (k == 2) ? 7'h00 : 7'h7F, -1);
            bseen = 0;
            repeat (5) begin
                @(negedge clk_Modulation);
                if (busy) bseen++;
            end
            chk("reject_busy", 32'(bseen), 32'd0);
            wait_drain(100);
        end

        // Underrun: byte 2 never offered
        src_limit = 2;
        issue_frame(4'b0101, 4, 7'h55, 2);
        wait_drain(3000);
        chk("underrun_busy_low", 32'(busy), 32'd0);
        chk("underrun_bytes_taken", 32'(src_sent), 32'd2);
        src_q.delete();
        src_limit = 1 << 30;
        issue_frame(4'b0101, 3, 7'h21, -1);
        wait_drain(3000);
        chk("after_underrun_bits", 32'(cap_bits.size()), 32'(24 + 48));

        // Start pulsed during DATA is ignored
        issue_frame(4'b0101, 6, 7'h3C, -1);
        repeat (40) @(posedge clk_Modulation);
        pulse_start(4'b1101, 2, 7'h11);
        wait_drain(3000);
        chk("start_in_data_bits", 32'(cap_bits.size()), 32'(24 + 96));

        // Reset asserted mid-PSDU
        issue_frame(4'b0011, 20, 7'h6A, -1);
        repeat (80) @(posedge clk_Modulation);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            32'({psdu_ready, enc_valid, enc_bit, enc_signal, busy, done, err}), 32'd0);
        exp_q.delete();
        src_q.delete();
        psdu_valid = 1'b0;
        repeat (3) @(posedge clk_Modulation);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_Modulation);
        issue_frame(4'b1111, 5, 7'h4B, -1);
        wait_drain(3000);
        chk("post_reset_bits", 32'(cap_bits.size()), 32'(24 + 72));

        // Randomised frames with stalling source
        src_rand = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [3:0] r;
            int         len;
            logic [6:0] sd;
            r   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            sd  = 7'($urandom);
            issue_frame(r, len, sd, -1);
            wait_drain(3000);
            if (ndbps(r) != 0 && len != 0 && sd != 7'd0)
                chk("rand_bytes_taken", 32'(src_sent), 32'(len));
            src_q.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
